// File: rtl/mul6b_seq_pkg.sv
// ============================================================================
// Module  : mul6b_seq_pkg
// Brief   : Shared widths and FSM state encoding for the 6x6 sequential multiplier.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mul6b_seq_pkg;

    localparam int unsigned HALF_W = 3;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned PP_W   = 6;
    localparam int unsigned PROD_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S0   = 3'd1,
        ST_S1   = 3'd2,
        ST_S2   = 3'd3,
        ST_S3   = 3'd4,
        ST_DONE = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mul6b_seq_mul3b.sv
// ============================================================================
// Module  : mul3b
// Brief   : 3x3-bit unsigned combinational multiplier, 6-bit product.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mul3b
    import mul6b_seq_pkg::*;
(
    input  logic [HALF_W-1:0] x,
    input  logic [HALF_W-1:0] y,
    output logic [PP_W-1:0]   z
);

    assign z = {{(PP_W-HALF_W){1'b0}}, x} * {{(PP_W-HALF_W){1'b0}}, y};

endmodule

`default_nettype wire

// File: rtl/mul6b_seq.sv
// ============================================================================
// Module  : mul6b_seq
// Brief   : 6x6 unsigned multiplier, four partial products through one 3x3 unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mul6b_seq
    import mul6b_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] p
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     a_q, a_d;
    logic [OP_W-1:0]     b_q, b_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]   p_q, p_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [HALF_W-1:0]   mul_x, mul_y;
    logic [PP_W-1:0]     mul_z;
    logic [PROD_W-1:0]   term;

    mul3b u_mul3b (
        .x (mul_x),
        .y (mul_y),
        .z (mul_z)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        p_d     = p_q;
        mul_x   = '0;
        mul_y   = '0;
        term    = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    state_d = ST_S0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_S0: begin
                mul_x   = a_q[HALF_W-1:0];
                mul_y   = b_q[HALF_W-1:0];
                term    = {{(PROD_W-PP_W){1'b0}}, mul_z};
                acc_d   = acc_q + term;
                state_d = ST_S1;
            end
            ST_S1: begin
                mul_x   = a_q[OP_W-1:HALF_W];
                mul_y   = b_q[HALF_W-1:0];
                term    = {{(PROD_W-PP_W-HALF_W){1'b0}}, mul_z, {HALF_W{1'b0}}};
                acc_d   = acc_q + term;
                state_d = ST_S2;
            end
            ST_S2: begin
                mul_x   = a_q[HALF_W-1:0];
                mul_y   = b_q[OP_W-1:HALF_W];
                term    = {{(PROD_W-PP_W-HALF_W){1'b0}}, mul_z, {HALF_W{1'b0}}};
                acc_d   = acc_q + term;
                state_d = ST_S3;
            end
            ST_S3: begin
                mul_x   = a_q[OP_W-1:HALF_W];
                mul_y   = b_q[OP_W-1:HALF_W];
                term    = {mul_z, {(PROD_W-PP_W){1'b0}}};
                acc_d   = acc_q + term;
                // Final term goes straight into p so it is valid in the DONE cycle.
                p_d     = acc_q + term;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Flags follow the next state so they line up with the registered state.
    assign busy_d = (state_d == ST_S0) || (state_d == ST_S1) ||
                    (state_d == ST_S2) || (state_d == ST_S3);
    assign done_d = (state_d == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

`default_nettype wire

// File: tb/tb_mul6b_seq.sv
// ============================================================================
// Module  : tb_mul6b_seq
// Brief   : Self-checking bench: vector table, random products, timing corners.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul6b_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  a;
    logic [5:0]  b;
    logic        busy;
    logic        done;
    logic [11:0] p;

    int total = 0;
    int bad   = 0;
    int last_p = 0;

    mul6b_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  va;
        logic [5:0]  vb;
        logic [11:0] vp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One full operation; operands are scrambled while busy, and optionally a
    // stray start (with a=2) is raised during S2.
    task automatic do_mul(input logic [5:0] ta, input logic [5:0] tb_,
                          input int exp, input string nm, input bit poke);
        @(negedge clk);
        a = ta; b = tb_; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, " p_hold"}, int'(p), last_p);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk({nm, " busy"}, int'(busy), 1);
            chk({nm, " done_early"}, int'(done), 0);
            a = 6'($urandom);
            b = 6'($urandom);
            start = 1'b0;
            if (poke && i == 2) begin
                a = 6'd2;
                start = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk({nm, " done"}, int'(done), 1);
        chk({nm, " busy_at_done"}, int'(busy), 0);
        chk({nm, " p"}, int'(p), exp);
        last_p = exp;
        @(negedge clk);
        chk({nm, " done_after"}, int'(done), 0);
        chk({nm, " busy_after"}, int'(busy), 0);
        chk({nm, " p_after"}, int'(p), exp);
    endtask

    initial begin
        vecs[0] = '{6'd45, 6'd27, 12'd1215};
        vecs[1] = '{6'd63, 6'd63, 12'd3969};
        vecs[2] = '{6'd0,  6'd63, 12'd0};
        vecs[3] = '{6'd1,  6'd1,  12'd1};
        vecs[4] = '{6'd8,  6'd8,  12'd64};
        vecs[5] = '{6'd12, 6'd5,  12'd60};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset p", int'(p), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle no_done", int'(done), 0);
        end

        for (int i = 0; i < 6; i++)
            do_mul(vecs[i].va, vecs[i].vb, int'(vecs[i].vp), $sformatf("vec%0d", i), 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic [5:0] ra, rb;
            ra = 6'($urandom);
            rb = 6'($urandom);
            do_mul(ra, rb, int'(ra) * int'(rb), $sformatf("rand%0d", i), 1'b0);
        end

        do_mul(6'd10, 6'd10, 100, "stray_start", 1'b1);

        // Start held high: a result every 5 cycles.
        @(negedge clk);
        a = 6'd7; b = 6'd9; start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk($sformatf("b2b done k%0d", k), int'(done), (k % 5 == 0) ? 1 : 0);
            chk($sformatf("b2b busy k%0d", k), int'(busy), (k % 5 == 0) ? 0 : 1);
            if (k % 5 == 0)
                chk($sformatf("b2b p k%0d", k), int'(p), 63);
        end
        start = 1'b0;
        last_p = 63;
        @(negedge clk);
        chk("b2b idle", int'(busy), 0);

        // Reset during S2 discards the operation.
        a = 6'd50; b = 6'd40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst p", int'(p), 0);
        last_p = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("midrst no_done", int'(done), 0);
        end
        do_mul(6'd3, 6'd3, 9, "after_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mul6b_seq.md
# mul6b_seq

Sequential 6x6-bit unsigned multiplier built around one shared 3x3-bit combinational multiplier. It splits each operand into 3-bit halves and feeds the four partial-product pairs through the single multiplier over four cycles, accumulating a 12-bit product. It trades latency for area and is the sequencing controller for the 3-bit multiplier datapath, sitting between a start/done requester and that resource.

## Interface
- No parameters; widths are fixed at 6-bit operands and a 12-bit product.
- clk: input, 1 bit. Single clock; all state is updated on its rising edge.
- rst: input, 1 bit. Synchronous, active-high reset.
- start: input, 1 bit. Request pulse, sampled only in IDLE or DONE.
- a: input, 6 bits. Multiplicand, unsigned; captured when start is accepted.
- b: input, 6 bits. Multiplier, unsigned; captured when start is accepted.
- busy: output, 1 bit. High while a multiplication is in progress.
- done: output, 1 bit. One-cycle pulse; p is valid in that cycle.
- p: output, 12 bits. Product; held until the next accepted start or reset.

## Operation
- Operand split: a_lo = a[2:0], a_hi = a[5:3], b_lo = b[2:0], b_hi = b[5:3].
- FSM states: IDLE, S0, S1, S2, S3, DONE.
- IDLE:
  - Accepts start=1: latches a and b into internal registers, clears the accumulator, and moves to S0.
  - With start=0, stays in IDLE.
- Step schedule. The multiplier inputs are driven from the latched operand halves selected by the state:
  - S0: a_lo*b_lo, added with shift 0.
  - S1: a_hi*b_lo, added with shift 3.
  - S2: a_lo*b_hi, added with shift 3.
  - S3: a_hi*b_hi, added with shift 6.
- Each step adds the 6-bit partial product, zero-extended and shifted, into a 12-bit accumulator.
- Overflow is impossible: the maximum product is 63*63 = 3969 < 4096. No wrap handling is required.
- After S3, moves to DONE. The accumulator value including the S3 term is registered into p, and done=1 for exactly one cycle.
- DONE:
  - start=1 is accepted exactly as in IDLE (back-to-back operation) and moves to S0.
  - Otherwise moves to IDLE.
- start in S0–S3 is ignored. There is no queueing, and the latched operands do not change.
- Changes on a and b after acceptance have no effect on the result.
- Reset, at any time including mid-operation:
  - State returns to IDLE.
  - Accumulator, operand registers and p are cleared to 0.
  - busy=0 and done=0 in the cycle after the reset edge.
  - The in-flight result is discarded; done never fires for it.
- Reset values: busy=0, done=0, p=12'h000.

## Timing
- start is sampled high at edge N (state IDLE or DONE). The FSM is then in S0 during cycle N..N+1.
- S0–S3 occupy 4 cycles; busy=1 throughout these 4 cycles.
- DONE occupies the cycle after edge N+4: done=1 and p holds the new product in that cycle.
- Latency from start to done is 5 edges. Throughput is one product per 5 cycles with back-to-back start.
- p updates only on the edge entering DONE. It is stable from then until the next DONE entry or reset.
- busy=0 in IDLE and DONE. busy and done are never high together.
- All outputs are registered; no combinational path from start, a or b to any output.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE, S0–S3, DONE as a 3-bit enumeration);
  - the operand width constant (3-bit half, 6-bit operand, 12-bit product).
- One sub-module: a single instance of the team's 3x3 combinational multiplier (mul3b: inputs x and y, 3 bits; output z, 6 bits).
  - Exactly one instance; no duplicate multipliers.
- Operand mux, shifter, accumulator and FSM live in mul6b_seq itself.
- Target size: roughly 150–250 lines of RTL.

## Test plan
- Reset, then idle: assert rst for 2 cycles -> p=0, busy=0, done=0. No done pulse over the following 10 cycles with start=0.
- Basic product: a=6'd45, b=6'd27, start for 1 cycle -> busy high for 4 cycles, then done=1 for 1 cycle with p=12'd1215. p holds 1215 afterwards.
- Corner values:
  - a=63, b=63 -> p=3969.
  - a=0, b=63 -> p=0.
  - a=1, b=1 -> p=1.
  - a=8, b=8 -> p=64 (only the hi*hi term is nonzero).
- Back-to-back and ignored start:
  - start held high continuously with a=7, b=9 -> done every 5 cycles, p=63 each time.
  - A start pulse with a=2 during S2 -> ignored; the result is unchanged.
- Operand stability: change a and b on every cycle after acceptance of a=12, b=5 -> p=60.
- Reset mid-operation: assert rst during S2 of a=50, b=40 -> next cycle busy=0, p=0. No done pulse follows. A subsequent start with a=3, b=3 -> p=9.
